wb_region_mux: RTL and testbench

WB_REGION_MUX -- requirements
Module: wb_region_mux

---
 rtl/wb_region_mux.sv | 184 ++++++++++++++++++
 tb/tb_wb_region_mux.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_region_mux.sv
// wb_region_mux: Wishbone address-region demux with slave timeout and a 2-register debug window.
// Revision 1.0
`default_nettype none

module wb_region_mux #(
  parameter int          NUM_REGIONS    = 4,
  parameter int          REGION_LSB     = 16,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] DBG_BASE       = 32'h300F_FFF8
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_adr_i,
  input  logic [31:0]              wbs_dat_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  output logic [NUM_REGIONS-1:0]   s_cyc_o,
  output logic                     s_stb_o,
  output logic                     s_we_o,
  output logic [3:0]               s_sel_o,
  output logic [31:0]              s_adr_o,
  output logic [31:0]              s_dat_o,
  input  logic [NUM_REGIONS-1:0]   s_ack_i,
  input  logic [32*NUM_REGIONS-1:0] s_dat_i,
  output logic                     timeout_irq_o
);

  localparam int          RW        = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam logic [RW:0] c_NUM     = (RW+1)'(NUM_REGIONS);
  localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT_CYCLES);
  localparam logic [31:0] c_ERR     = 32'hDEAD_BEEF;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FWD  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    r_state;
  logic [RW-1:0] r_region;
  logic [15:0]   r_timer;
  logic [31:0]   r_dat;
  logic [31:0]   r_scratch;
  logic          r_ack;
  logic          r_sticky;
  logic [7:0]    r_tcnt;
  logic [2:0]    r_last;

  logic          w_req;
  logic          w_dbg_hit;
  logic [RW-1:0] w_idx;
  logic          w_oor;
  logic [15:0]   w_timer_nxt;
  logic          w_tmo;
  logic [31:0]   w_reg1;
  logic [31:0]   w_dbg_rd;
  logic [2:0]    w_region_ext;
  logic          w_sel_ack;
  logic [31:0]   w_sel_dat;
  logic          w_fwd;

  assign w_req       = wbs_cyc_i & wbs_stb_i;
  assign w_dbg_hit   = (wbs_adr_i[31:3] == DBG_BASE[31:3]);
  assign w_idx       = wbs_adr_i[REGION_LSB +: RW];
  assign w_oor       = ({1'b0, w_idx} >= c_NUM);
  assign w_timer_nxt = r_timer + 16'd1;
  assign w_tmo       = (w_timer_nxt == c_TIMEOUT);
  assign w_reg1      = {r_sticky, 20'd0, r_last, r_tcnt};
  assign w_dbg_rd    = wbs_adr_i[2] ? w_reg1 : r_scratch;
  assign w_fwd       = (r_state == S_FWD);

  always_comb begin
    w_region_ext           = '0;
    w_region_ext[RW-1:0]   = r_region;
  end

  // Only the latched region's ack/data are looked at; other acks are noise.
  always_comb begin
    w_sel_ack = 1'b0;
    w_sel_dat = '0;
    for (int r = 0; r < NUM_REGIONS; r++) begin
      if (r_region == RW'(r)) begin
        w_sel_ack = s_ack_i[r];
        w_sel_dat = s_dat_i[32*r +: 32];
      end
    end
  end

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_cyc
    assign s_cyc_o[g] = w_fwd & wbs_cyc_i & (r_region == RW'(g));
  end

  assign s_stb_o       = w_fwd & wbs_stb_i;
  assign s_we_o        = wbs_we_i;
  assign s_sel_o       = wbs_sel_i;
  assign s_adr_o       = wbs_adr_i;
  assign s_dat_o       = wbs_dat_i;
  assign wbs_ack_o     = r_ack;
  assign wbs_dat_o     = r_dat;
  assign timeout_irq_o = r_sticky;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= S_IDLE;
      r_region  <= '0;
      r_timer   <= '0;
      r_dat     <= '0;
      r_scratch <= '0;
      r_ack     <= 1'b0;
      r_sticky  <= 1'b0;
      r_tcnt    <= '0;
      r_last    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ack   <= 1'b0;
          r_timer <= '0;
          if (w_req) begin
            if (w_dbg_hit) begin
              r_state <= S_RESP;
              r_ack   <= 1'b1;
              if (wbs_we_i) begin
                r_dat <= '0;
                if (wbs_adr_i[2]) begin
                  r_sticky <= 1'b0;
                  r_tcnt   <= '0;
                  r_last   <= '0;
                end else begin
                  for (int b = 0; b < 4; b++) begin
                    if (wbs_sel_i[b]) r_scratch[8*b +: 8] <= wbs_dat_i[8*b +: 8];
                  end
                end
              end else begin
                r_dat <= w_dbg_rd;
              end
            end else if (w_oor) begin
              r_dat   <= c_ERR;
              r_state <= S_RESP;
              r_ack   <= 1'b1;
            end else begin
              r_region <= w_idx;
              r_state  <= S_FWD;
            end
          end
        end
        S_FWD: begin
          if (!wbs_cyc_i) begin
            r_state <= S_IDLE;
            r_timer <= '0;
          end else if (w_sel_ack) begin
            // An ack on the timeout cycle still counts as a normal completion.
            r_dat   <= w_sel_dat;
            r_state <= S_RESP;
            r_ack   <= 1'b1;
            r_timer <= '0;
          end else if (w_tmo) begin
            r_dat    <= c_ERR;
            r_state  <= S_RESP;
            r_ack    <= 1'b1;
            r_timer  <= '0;
            r_sticky <= 1'b1;
            r_last   <= w_region_ext;
            if (r_tcnt != 8'hFF) r_tcnt <= r_tcnt + 8'd1;
          end else begin
            r_timer <= w_timer_nxt;
          end
        end
        S_RESP: begin
          r_ack   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_ack   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_region_mux.sv
// tb_wb_region_mux: directed vectors with a scoreboard queue checked by an ack monitor.
// Revision 1.0
`default_nettype none

module tb_wb_region_mux;

  localparam int NR  = 3;
  localparam int TMO = 8;
  localparam logic [31:0] REG0 = 32'h300F_FFF8;
  localparam logic [31:0] REG1 = 32'h300F_FFFC;

  logic            clk = 1'b0;
  logic            rst;
  logic            cyc, stb, we;
  logic [3:0]      sel;
  logic [31:0]     adr, wdat;
  logic            ack;
  logic [31:0]     rdat;
  logic [NR-1:0]   s_cyc;
  logic            s_stb, s_we;
  logic [3:0]      s_sel;
  logic [31:0]     s_adr, s_dat;
  logic [NR-1:0]   s_ack;
  logic [32*NR-1:0] s_din;
  logic            irq;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  int          sl_delay = 0;
  bit          sl_noise = 1'b0;
  int          sl_cnt = 0;

  always #5 clk = ~clk;

  wb_region_mux #(
    .NUM_REGIONS(NR), .REGION_LSB(16), .TIMEOUT_CYCLES(TMO), .DBG_BASE(32'h300F_FFF8)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_dat), .s_ack_i(s_ack), .s_dat_i(s_din),
    .timeout_irq_o(irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every ack must match the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (ack === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_ack: got ack with data %h, expected no ack", rdat);
        end else begin
          check("ack_data", rdat, exp_q.pop_front());
        end
      end
    end
  end

  // Slave model: acks its own region after sl_delay cycles of s_cyc; optional noise on other ack bits.
  initial begin
    s_ack = '0;
    forever begin
      @(negedge clk);
      if (|s_cyc) begin
        sl_cnt++;
        s_ack = ((sl_delay != 0 && sl_cnt >= sl_delay) ? s_cyc : '0) | (sl_noise ? ~s_cyc : '0);
      end else begin
        sl_cnt = 0;
        s_ack  = '0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic xfer(input string name, input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input logic [31:0] exp_d, input int exp_lat,
                      input int exp_ncyc, input logic [NR-1:0] exp_seen);
    int            lat;
    int            ncyc;
    logic [NR-1:0] seen;
    bit            got;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
    exp_q.push_back(exp_d);
    lat = 0; ncyc = 0; seen = '0; got = 1'b0;
    while (!got && lat < 64) begin
      @(negedge clk);
      lat++;
      seen |= s_cyc;
      if (s_cyc != '0) ncyc++;
      if (ack === 1'b1) got = 1'b1;
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_ack_wait: no ack after %0d cycles, expected ack", name, lat);
      void'(exp_q.pop_back());
    end
    if (exp_lat > 0) check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    if (exp_ncyc >= 0) check({name, "_scyc_cycles"}, 32'(ncyc), 32'(exp_ncyc));
    check({name, "_scyc_onehot"}, 32'(seen), 32'(exp_seen));
    check({name, "_pass_adr"}, s_adr, a);
    check({name, "_pass_dat"}, s_dat, d);
    check({name, "_pass_we_sel"}, {27'd0, s_we, s_sel}, {27'd0, w, s});
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    check({name, "_ack_single"}, {31'd0, ack}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; wdat = '0;
    s_din = {32'h1234_5678, 32'h1111_1111, 32'h0000_AAAA};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_dat", rdat, 32'd0);
    check("rst_scyc_stb", {28'd0, s_cyc, s_stb}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);

    // Debug scratch: byte-lane write, then readback; debug decode wins over out-of-range index 3.
    xfer("dbg_wr0", 1'b1, REG0, 4'b0101, 32'hAABB_CCDD, 32'h0, 2, 0, '0);
    xfer("dbg_rd0", 1'b0, REG0, 4'hF, 32'h0, 32'h00BB_00DD, 2, 0, '0);

    sl_delay = 3;
    xfer("fwd_r2", 1'b0, 32'h3002_0010, 4'hF, 32'h0, 32'h1234_5678, 5, 3, 3'b100);

    sl_delay = 2; sl_noise = 1'b1;
    xfer("fwd_r0_noise", 1'b1, 32'h3000_0040, 4'b0011, 32'h5555_6666, 32'h0000_AAAA, 4, 2, 3'b001);
    sl_noise = 1'b0;

    // Ack on the very cycle the timer reaches its limit is a normal completion.
    sl_delay = TMO;
    xfer("ack_at_limit", 1'b0, 32'h3001_0000, 4'hF, 32'h0, 32'h1111_1111, TMO + 2, TMO, 3'b010);
    xfer("reg1_after_limit", 1'b0, REG1, 4'hF, 32'h0, 32'h0, 2, 0, '0);
    check("irq_after_limit", {31'd0, irq}, 32'd0);

    sl_delay = 0;
    xfer("timeout_r1", 1'b0, 32'h3001_0000, 4'hF, 32'h0, 32'hDEAD_BEEF, 0, -1, 3'b010);
    check("irq_after_timeout", {31'd0, irq}, 32'd1);
    xfer("reg1_after_tmo", 1'b0, REG1, 4'hF, 32'h0, 32'h8000_0101, 2, 0, '0);

    xfer("oor_r3", 1'b0, 32'h3003_0000, 4'hF, 32'h0, 32'hDEAD_BEEF, 2, 0, '0);
    xfer("reg1_after_oor", 1'b0, REG1, 4'hF, 32'h0, 32'h8000_0101, 2, 0, '0);

    xfer("reg1_clear", 1'b1, REG1, 4'hF, 32'h0, 32'h0, 2, 0, '0);
    check("irq_after_clear", {31'd0, irq}, 32'd0);
    xfer("reg1_cleared", 1'b0, REG1, 4'hF, 32'h0, 32'h0, 2, 0, '0);

    // Master abort in FWD: no ack, no timeout recorded even after the limit elapses.
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0040; sel = 4'hF;
    repeat (3) @(negedge clk);
    check("abort_fwd_scyc", 32'(s_cyc), 32'(3'b001));
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check("abort_scyc_off", 32'(s_cyc), 32'd0);
    repeat (TMO + 4) @(negedge clk);
    check("abort_no_ack", {31'd0, ack}, 32'd0);
    xfer("reg1_after_abort", 1'b0, REG1, 4'hF, 32'h0, 32'h0, 2, 0, '0);

    // Reset in FWD with the master still holding cyc: transaction abandoned.
    xfer("dbg_wr0_full", 1'b1, REG0, 4'hF, 32'hCAFE_F00D, 32'h0, 2, 0, '0);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3001_0000; sel = 4'hF;
    repeat (2) @(negedge clk);
    check("rstfwd_scyc", 32'(s_cyc), 32'(3'b010));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstfwd_scyc_off", 32'(s_cyc), 32'd0);
    check("rstfwd_no_ack", {31'd0, ack}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check("rstfwd_dat", rdat, 32'd0);
    xfer("dbg_rd0_after_rst", 1'b0, REG0, 4'hF, 32'h0, 32'h0, 2, 0, '0);
    sl_delay = 1;
    xfer("fwd_r2_after_rst", 1'b0, 32'h3002_0010, 4'hF, 32'h0, 32'h1234_5678, 3, 1, 3'b100);

    xfer("dbg_wr0_hi", 1'b1, REG0, 4'b1010, 32'h1122_3344, 32'h0, 2, 0, '0);
    xfer("dbg_rd0_hi", 1'b0, REG0, 4'hF, 32'h0, 32'h1100_3300, 2, 0, '0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
